// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - D-stage register, regfile, forwarding resolve, hazard stall and D/E pipeline register
module operand_issue_stage #(
    parameter int XLEN      = 32,
    parameter int NFWD      = 2,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_valid,
    output logic                 f_ready,
    input  logic [31:0]          f_instr,
    input  logic [31:0]          f_pc,
    input  logic                 d_use_rs,
    input  logic                 d_use_rt,
    input  logic [4:0]           d_dst,
    input  logic                 d_we,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 w_we,
    input  logic [4:0]           w_addr,
    input  logic [XLEN-1:0]      w_data,
    input  logic                 flush,
    input  logic                 e_ready,
    output logic                 e_valid,
    output logic [31:0]          e_instr,
    output logic [31:0]          e_pc,
    output logic [XLEN-1:0]      e_rs_val,
    output logic [XLEN-1:0]      e_rt_val,
    output logic [4:0]           e_a3,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic            d_valid;
    logic [31:0]     d_instr;
    logic [31:0]     d_pc;
    logic [XLEN-1:0] rf [32];

    logic [4:0]      op_addr [2];
    logic            op_use  [2];
    logic [XLEN-1:0] op_val  [2];
    logic            op_haz  [2];
    logic            hazard;
    logic            issue;

    assign op_addr[0] = d_instr[25:21];
    assign op_addr[1] = d_instr[20:16];
    assign op_use[0]  = d_use_rs;
    assign op_use[1]  = d_use_rt;

    // Youngest matching slot wins; a pending match stalls instead of supplying data.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            logic hit;
            hit        = 1'b0;
            op_val[op] = '0;
            op_haz[op] = 1'b0;
            if (op_use[op] && op_addr[op] != 5'd0) begin
                for (int k = 0; k < NFWD; k++) begin
                    if (!hit && fwd_valid[k] && fwd_addr[k*5 +: 5] == op_addr[op]) begin
                        hit        = 1'b1;
                        op_haz[op] = fwd_pending[k];
                        op_val[op] = fwd_data[k*XLEN +: XLEN];
                    end
                end
                if (!hit) begin
                    if (WB_BYPASS != 0 && w_we && w_addr == op_addr[op])
                        op_val[op] = w_data;
                    else
                        op_val[op] = rf[op_addr[op]];
                end
            end
        end
    end

    assign hazard  = d_valid && (op_haz[0] || op_haz[1]);
    assign issue   = d_valid && !hazard && e_ready && !flush;
    assign f_ready = !flush && (!d_valid || issue);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (w_we && w_addr != 5'd0) begin
            rf[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_valid <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (f_valid && f_ready) begin
            d_valid <= 1'b1;
            d_instr <= f_instr;
            d_pc    <= f_pc;
        end else if (issue) begin
            d_valid <= 1'b0;
        end
    end

    // Without e_ready nothing changes here unless a flush kills the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid  <= 1'b0;
            e_instr  <= '0;
            e_pc     <= '0;
            e_rs_val <= '0;
            e_rt_val <= '0;
            e_a3     <= '0;
        end else if (issue) begin
            e_valid  <= 1'b1;
            e_instr  <= d_instr;
            e_pc     <= d_pc;
            e_rs_val <= op_val[0];
            e_rt_val <= op_val[1];
            e_a3     <= d_we ? d_dst : 5'd0;
        end else if (e_ready || flush) begin
            e_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (hazard && !flush && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb/tb_operand_issue_stage.sv - directed and randomized checks of operand_issue_stage against a behavioural model
module tb_operand_issue_stage;
    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int CW   = 12;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic f_valid, f_ready;
    logic [31:0] f_instr, f_pc;
    logic d_use_rs, d_use_rt, d_we;
    logic [4:0] d_dst;
    logic [NFWD-1:0] fwd_valid, fwd_pending;
    logic [5*NFWD-1:0] fwd_addr;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic w_we;
    logic [4:0] w_addr;
    logic [XLEN-1:0] w_data;
    logic flush, e_ready, e_valid;
    logic [31:0] e_instr, e_pc;
    logic [XLEN-1:0] e_rs_val, e_rt_val;
    logic [4:0] e_a3;
    logic [CW-1:0] stall_cnt;

    operand_issue_stage #(.XLEN(XLEN), .NFWD(NFWD), .WB_BYPASS(1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_ready(f_ready),
        .f_instr(f_instr), .f_pc(f_pc), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_dst(d_dst), .d_we(d_we), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .w_we(w_we), .w_addr(w_addr),
        .w_data(w_data), .flush(flush), .e_ready(e_ready), .e_valid(e_valid),
        .e_instr(e_instr), .e_pc(e_pc), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .e_a3(e_a3), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic t_fv, t_wwe, t_fl, t_er;
    logic [31:0] t_fi, t_fp;
    logic t_fwv [NFWD];
    logic t_fwp [NFWD];
    logic [4:0] t_fwa [NFWD];
    logic [31:0] t_fwd [NFWD];
    logic [4:0] t_wa;
    logic [31:0] t_wd;

    logic [31:0] m_rf [32];
    logic m_dv, m_ev;
    logic [31:0] m_di, m_dp, m_ei, m_ep, m_ers, m_ert;
    logic [4:0] m_ea3;
    int m_cnt;
    logic exp_fready, obs_fready;

    // Bench-side decode: opcode bits carry the operand-use and write flags.
    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic urs, input logic urt, input logic we,
                                       input logic [4:0] dst);
        logic [10:0] tag;
        tag = 11'($urandom);
        return {3'b000, we, urt, urs, rs, rt, dst, tag};
    endfunction

    function automatic void resolve(input logic [4:0] a, input logic u,
                                    output logic [31:0] v, output logic h);
        v = '0;
        h = 1'b0;
        if (!u || a == 5'd0) return;
        for (int k = 0; k < NFWD; k++) begin
            if (t_fwv[k] && t_fwa[k] == a) begin
                h = t_fwp[k];
                v = t_fwd[k];
                return;
            end
        end
        v = (t_wwe && t_wa == a) ? t_wd : m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_dv = 0; m_ev = 0; m_di = '0; m_dp = '0;
        m_ei = '0; m_ep = '0; m_ers = '0; m_ert = '0; m_ea3 = '0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        t_fv = 0; t_fi = '0; t_fp = '0; t_wwe = 0; t_wa = '0; t_wd = '0;
        t_fl = 0; t_er = 1;
        for (int k = 0; k < NFWD; k++) begin
            t_fwv[k] = 0; t_fwp[k] = 0; t_fwa[k] = '0; t_fwd[k] = '0;
        end
    endtask

    task automatic cycle();
        logic [31:0] rsv, rtv;
        logic hr, ht, haz, iss;
        f_valid = t_fv; f_instr = t_fi; f_pc = t_fp;
        d_use_rs = m_di[26]; d_use_rt = m_di[27]; d_we = m_di[28]; d_dst = m_di[15:11];
        for (int k = 0; k < NFWD; k++) begin
            fwd_valid[k] = t_fwv[k];
            fwd_pending[k] = t_fwp[k];
            fwd_addr[k*5 +: 5] = t_fwa[k];
            fwd_data[k*XLEN +: XLEN] = t_fwd[k];
        end
        w_we = t_wwe; w_addr = t_wa; w_data = t_wd; flush = t_fl; e_ready = t_er;
        #1;
        resolve(m_di[25:21], m_di[26], rsv, hr);
        resolve(m_di[20:16], m_di[27], rtv, ht);
        haz = m_dv && (hr || ht);
        iss = m_dv && !haz && t_er && !t_fl;
        exp_fready = !t_fl && (!m_dv || iss);
        obs_fready = f_ready;
        @(posedge clk);
        if (iss) begin
            m_ev = 1; m_ei = m_di; m_ep = m_dp; m_ers = rsv; m_ert = rtv;
            m_ea3 = m_di[28] ? m_di[15:11] : 5'd0;
        end else if (t_er || t_fl) begin
            m_ev = 0;
        end
        if (t_fl) m_dv = 0;
        else if (t_fv && exp_fready) begin m_dv = 1; m_di = t_fi; m_dp = t_fp; end
        else if (iss) m_dv = 0;
        if (haz && !t_fl && m_cnt < CMAX) m_cnt++;
        if (t_wwe && t_wa != 5'd0) m_rf[t_wa] = t_wd;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] x;
        idle_inputs();
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL rst_e_valid got=%0b exp=0", e_valid); end
        checks++; if (e_instr !== 32'h0) begin failures++; $display("FAIL rst_e_instr got=%h exp=0", e_instr); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        x = mk(5'd2, 5'd0, 1, 0, 1, 5'd7);
        t_fv = 1; t_fi = x; t_fp = 32'h100; t_wwe = 1; t_wa = 5'd5; t_wd = 32'hDEAD;
        cycle();
        t_fv = 0; t_wwe = 0;
        t_fwv[0] = 1; t_fwp[0] = 1; t_fwa[0] = 5'd2;
        cycle();
        t_fwv[0] = 0; t_fwp[0] = 0;
        cycle();
        checks++; if (e_valid !== 1'b1 || stall_cnt !== CW'(1)) begin failures++;
            $display("FAIL pre_rst_state got=%0b/%0d exp=1/1", e_valid, stall_cnt); end
        #2 reset = 1;
        #1;
        checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL async_rst_e_valid got=%0b exp=0", e_valid); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL async_rst_stall got=%0d exp=0", stall_cnt); end
        model_reset();
        @(negedge clk);
        reset = 0;
        x = mk(5'd5, 5'd0, 1, 0, 0, 5'd0);
        t_fv = 1; t_fi = x; t_fp = 32'h200;
        cycle();
        t_fv = 0;
        cycle();
        checks++; if (e_valid !== 1'b1 || e_instr !== x) begin failures++;
            $display("FAIL rst_first_accept got=%0b/%h exp=1/%h", e_valid, e_instr, x); end
        checks++; if (e_rs_val !== 32'h0) begin failures++; $display("FAIL rst_reg5 got=%h exp=0", e_rs_val); end
    endtask

    task automatic test_write_through();
        logic [31:0] x;
        idle_inputs();
        x = mk(5'd8, 5'd0, 1, 0, 1, 5'd3);
        t_fv = 1; t_fi = x; t_fp = 32'h300;
        cycle();
        t_fv = 0; t_wwe = 1; t_wa = 5'd8; t_wd = 32'h1234;
        cycle();
        checks++; if (e_rs_val !== 32'h1234) begin failures++; $display("FAIL wt_rs got=%h exp=1234", e_rs_val); end
        checks++; if (e_a3 !== 5'd3 || e_pc !== 32'h300) begin failures++;
            $display("FAIL wt_a3_pc got=%0d/%h exp=3/300", e_a3, e_pc); end
        t_wwe = 0;
        x = mk(5'd8, 5'd8, 1, 1, 0, 5'd9);
        t_fv = 1; t_fi = x;
        cycle();
        t_fv = 0;
        cycle();
        checks++; if (e_rs_val !== 32'h1234 || e_rt_val !== 32'h1234 || e_a3 !== 5'd0) begin failures++;
            $display("FAIL wt_regfile got=%h/%h/%0d exp=1234/1234/0", e_rs_val, e_rt_val, e_a3); end
    endtask

    task automatic test_priority();
        idle_inputs();
        t_fv = 1; t_fi = mk(5'd9, 5'd0, 1, 1, 0, 5'd0);
        cycle();
        t_fv = 0;
        t_fwv[0] = 1; t_fwa[0] = 5'd9; t_fwd[0] = 32'hA;
        t_fwv[1] = 1; t_fwa[1] = 5'd9; t_fwd[1] = 32'hB;
        cycle();
        checks++; if (e_valid !== 1'b1 || e_rs_val !== 32'hA) begin failures++;
            $display("FAIL prio_slot0 got=%0b/%h exp=1/a", e_valid, e_rs_val); end
        checks++; if (e_rt_val !== 32'h0) begin failures++; $display("FAIL prio_rt0 got=%h exp=0", e_rt_val); end
        idle_inputs();
        t_fv = 1; t_fi = mk(5'd0, 5'd0, 1, 1, 0, 5'd0);
        cycle();
        t_fv = 0;
        t_fwv[0] = 1; t_fwp[0] = 1; t_fwa[0] = 5'd0; t_fwd[0] = 32'h55;
        t_fwv[1] = 1; t_fwa[1] = 5'd0; t_fwd[1] = 32'h66;
        t_wwe = 1; t_wa = 5'd0; t_wd = 32'h77;
        cycle();
        checks++; if (e_valid !== 1'b1 || e_rs_val !== 32'h0 || e_rt_val !== 32'h0) begin failures++;
            $display("FAIL prio_r0 got=%0b/%h/%h exp=1/0/0", e_valid, e_rs_val, e_rt_val); end
    endtask

    task automatic test_load_use();
        logic [31:0] n;
        int c0;
        idle_inputs();
        t_fv = 1; t_fi = mk(5'd0, 5'd4, 0, 1, 1, 5'd6);
        cycle();
        c0 = m_cnt;
        n = mk(5'd1, 5'd1, 0, 0, 0, 5'd0);
        t_fi = n; t_fp = 32'h400;
        t_fwv[0] = 1; t_fwp[0] = 1; t_fwa[0] = 5'd4; t_fwd[0] = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (obs_fready !== 1'b0 || e_valid !== 1'b0) begin failures++;
                $display("FAIL lu_stall%0d got=%0b/%0b exp=0/0", i, obs_fready, e_valid); end
        end
        checks++; if (stall_cnt !== CW'(c0 + 3)) begin failures++;
            $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, c0 + 3); end
        t_fwp[0] = 0; t_fwd[0] = 32'h77;
        cycle();
        checks++; if (obs_fready !== 1'b1 || e_valid !== 1'b1 || e_rt_val !== 32'h77 || e_a3 !== 5'd6) begin failures++;
            $display("FAIL lu_release got=%0b/%0b/%h/%0d exp=1/1/77/6", obs_fready, e_valid, e_rt_val, e_a3); end
        idle_inputs();
        cycle();
        checks++; if (e_valid !== 1'b1 || e_instr !== n) begin failures++;
            $display("FAIL lu_next got=%0b/%h exp=1/%h", e_valid, e_instr, n); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        idle_inputs();
        a = mk(5'd0, 5'd0, 0, 0, 0, 5'd0);
        b = mk(5'd0, 5'd0, 0, 0, 1, 5'd2);
        c = mk(5'd0, 5'd0, 0, 0, 1, 5'd4);
        t_fv = 1; t_fi = a; cycle();
        t_fi = b; cycle();
        checks++; if (e_instr !== a || e_valid !== 1'b1) begin failures++; $display("FAIL bp_a got=%h exp=%h", e_instr, a); end
        t_fi = c; t_er = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (obs_fready !== 1'b0 || e_valid !== 1'b1 || e_instr !== a) begin failures++;
                $display("FAIL bp_hold%0d got=%0b/%0b/%h exp=0/1/%h", i, obs_fready, e_valid, e_instr, a); end
        end
        t_er = 1;
        cycle();
        checks++; if (obs_fready !== 1'b1 || e_instr !== b || e_a3 !== 5'd2) begin failures++;
            $display("FAIL bp_b got=%0b/%h/%0d exp=1/%h/2", obs_fready, e_instr, e_a3, b); end
        t_fv = 0;
        cycle();
        checks++; if (e_valid !== 1'b1 || e_instr !== c) begin failures++; $display("FAIL bp_c got=%h exp=%h", e_instr, c); end
        cycle();
        checks++; if (e_valid !== 1'b0 || e_instr !== c) begin failures++;
            $display("FAIL bp_bubble got=%0b/%h exp=0/%h", e_valid, e_instr, c); end
    endtask

    task automatic test_flush();
        int c0;
        idle_inputs();
        t_fv = 1; t_fi = mk(5'd3, 5'd0, 1, 0, 0, 5'd0);
        cycle();
        t_fv = 0;
        t_fwv[0] = 1; t_fwp[0] = 1; t_fwa[0] = 5'd3;
        cycle();
        c0 = m_cnt;
        t_fl = 1; t_fv = 1; t_fi = mk(5'd0, 5'd0, 0, 0, 0, 5'd0);
        cycle();
        checks++; if (obs_fready !== 1'b0 || e_valid !== 1'b0 || stall_cnt !== CW'(c0)) begin failures++;
            $display("FAIL fl_cycle got=%0b/%0b/%0d exp=0/0/%0d", obs_fready, e_valid, stall_cnt, c0); end
        idle_inputs();
        cycle();
        checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL fl_d_cleared got=%0b exp=0", e_valid); end
        t_fv = 1; t_fi = mk(5'd0, 5'd0, 0, 0, 0, 5'd0);
        cycle();
        t_fv = 0;
        cycle();
        t_er = 0; t_fl = 1;
        cycle();
        checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL fl_e_noready got=%0b exp=0", e_valid); end
        idle_inputs();
        t_fv = 1; t_fi = mk(5'd3, 5'd0, 1, 0, 0, 5'd0);
        cycle();
        t_fv = 0;
        t_fwv[0] = 1; t_fwp[0] = 1; t_fwa[0] = 5'd3;
        for (int i = 0; i < CMAX + 40; i++) cycle();
        checks++; if (stall_cnt !== CW'(CMAX)) begin failures++;
            $display("FAIL sat_cnt got=%0d exp=%0d", stall_cnt, CMAX); end
        t_fl = 1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            t_fv = ($urandom % 4) != 0;
            t_fi = mk(5'($urandom % 8), 5'($urandom % 8), 1'($urandom), 1'($urandom),
                      1'($urandom), 5'($urandom % 8));
            t_fp = $urandom;
            for (int k = 0; k < NFWD; k++) begin
                t_fwv[k] = 1'($urandom);
                t_fwp[k] = ($urandom % 4) == 0;
                t_fwa[k] = 5'($urandom % 8);
                t_fwd[k] = $urandom;
            end
            t_wwe = 1'($urandom); t_wa = 5'($urandom % 8); t_wd = $urandom;
            t_fl = ($urandom % 16) == 0;
            t_er = ($urandom % 4) != 0;
            cycle();
            checks++; if (obs_fready !== exp_fready || e_valid !== m_ev || stall_cnt !== CW'(m_cnt)) begin failures++;
                $display("FAIL rnd_ctrl n=%0d got=%0b/%0b/%0d exp=%0b/%0b/%0d", n, obs_fready, e_valid,
                         stall_cnt, exp_fready, m_ev, m_cnt); end
            checks++; if (e_instr !== m_ei || e_pc !== m_ep || e_rs_val !== m_ers || e_rt_val !== m_ert || e_a3 !== m_ea3) begin
                failures++;
                $display("FAIL rnd_data n=%0d got=%h/%h/%h/%h/%0d exp=%h/%h/%h/%h/%0d", n, e_instr, e_pc,
                         e_rs_val, e_rt_val, e_a3, m_ei, m_ep, m_ers, m_ert, m_ea3); end
        end
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
